maquina_de_saida: RTL
=====================

Name: maquina_de_saida

Overview:
- Exit-side controller for the parking access system. It is the counterpart of the entry machine.
- Opens the exit gate when a vehicle presents at the inner exit sensor, confirms passage via the outer exit sensor, and closes the gate on completion or timeout.
- Owns the occupancy counter: +1 on each confirmed entry pulse from the entry machine, −1 on each confirmed exit.
- Drives the `cheio` flag consumed by the entry machine, plus a `vazio` flag and the occupied-slot count for the display.

Parameters:
- VAGAS, 16, parking capacity; `cheio` asserts when occupancy equals VAGAS.
- TEMPO_LIMITE, 1000, clock cycles the gate stays open waiting for the vehicle to reach the outer sensor; must be ≥ 2.
- W, $clog2(VAGAS+1), derived width of the occupancy count; not to be overridden.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- SENSOR_INTERNO_SAIDA  in  1  vehicle present at the inner side of the exit gate; already synchronised and debounced.
- SENSOR_EXTERNO_SAIDA  in  1  vehicle present at the outer side of the exit gate; already synchronised and debounced.
- ENTRADA_CONFIRMADA  in  1  one-cycle pulse from the entry machine when a vehicle completes entry.
- STATUS_DA_CANCELA_DE_SAIDA  out  1  1 = exit gate open.
- cheio  out  1  occupancy == VAGAS.
- vazio  out  1  occupancy == 0.
- VAGAS_OCUPADAS  out  W  current occupancy.
- ERRO_DE_CONTAGEM  out  1  one-cycle pulse on a saturated (rejected) count update.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state = OCIOSA, occupancy = 0, timer = 0.
  - STATUS_DA_CANCELA_DE_SAIDA = 0, cheio = 0, vazio = 1, ERRO_DE_CONTAGEM = 0.
  - Reset mid-operation closes the gate on the next edge and clears occupancy.
- States, 2-bit encoding: OCIOSA = 00, CANCELA_ABERTA = 01, VEICULO_PASSANDO = 10; 11 is unused and recovers to OCIOSA.
- OCIOSA:
  - SENSOR_INTERNO_SAIDA = 1 → CANCELA_ABERTA, timer cleared.
  - Otherwise stay.
- CANCELA_ABERTA:
  - Timer increments each cycle.
  - SENSOR_EXTERNO_SAIDA = 1 → VEICULO_PASSANDO. This has priority over the timeout.
  - Else timer == TEMPO_LIMITE−1 → OCIOSA, with no count change.
- VEICULO_PASSANDO (timer held):
  - SENSOR_EXTERNO_SAIDA = 0 and SENSOR_INTERNO_SAIDA = 0 → OCIOSA and an exit event.
  - SENSOR_EXTERNO_SAIDA = 0 and SENSOR_INTERNO_SAIDA = 1 (vehicle reversed) → CANCELA_ABERTA, timer cleared, no count change.
  - Otherwise stay.
- Gate output is registered: 1 in CANCELA_ABERTA and VEICULO_PASSANDO, 0 in OCIOSA. It asserts one cycle after the edge that samples SENSOR_INTERNO_SAIDA = 1.
- Occupancy update happens on the same edge as the exit transition and is registered:
  - Entry only: +1; if already VAGAS, hold and pulse ERRO_DE_CONTAGEM.
  - Exit only: −1; if already 0, hold and pulse ERRO_DE_CONTAGEM.
  - Entry and exit in the same cycle: unchanged, no error. This applies even at 0 or VAGAS.
- cheio, vazio and VAGAS_OCUPADAS are combinational from the occupancy register, so they reflect the new value in the cycle after the update edge.
- ERRO_DE_CONTAGEM is registered and lasts exactly one cycle.
- ENTRADA_CONFIRMADA is honoured in every state.

Decomposition:
- Shared package holds:
  - state encodings OCIOSA, CANCELA_ABERTA, VEICULO_PASSANDO;
  - default VAGAS;
  - default TEMPO_LIMITE.
  The entry machine reuses VAGAS.
- One sub-module is natural: `contador_de_vagas`, a saturating up/down counter with ERRO_DE_CONTAGEM, cheio and vazio. The FSM and timer stay in the top module.

Test Plan (VAGAS=4, TEMPO_LIMITE=8):
- Normal exit: after reset, pulse ENTRADA_CONFIRMADA ×2 → VAGAS_OCUPADAS = 2. Then INTERNO = 1 for 2 cycles, INTERNO = 0 with EXTERNO = 1 for 3 cycles, then EXTERNO = 0 → gate 1 from cycle after INTERNO sampled, gate 0 after EXTERNO falls, VAGAS_OCUPADAS = 1.
- Timeout: INTERNO = 1 pulse, EXTERNO never asserted → gate open exactly 8 cycles then 0, occupancy unchanged, state OCIOSA.
- Full/saturation: 5 entry pulses → occupancy 4, cheio = 1 from the 4th update, ERRO_DE_CONTAGEM pulses once on the 5th. One exit → cheio = 0, occupancy 3.
- Empty exit: occupancy 0, full exit sequence → occupancy stays 0, vazio stays 1, ERRO_DE_CONTAGEM one-cycle pulse, gate closes normally.
- Simultaneous: occupancy 4, ENTRADA_CONFIRMADA pulse on the exit-completion edge → occupancy stays 4, no error, cheio stays 1.
- Reversal and reset: in VEICULO_PASSANDO, drop EXTERNO with INTERNO = 1 → back to CANCELA_ABERTA, gate stays 1, count unchanged. Then assert rst_n = 0 for one edge → gate 0, occupancy 0, vazio = 1 on that edge.

Source files
------------

// File: rtl/maquina_de_saida_pkg.sv
// Shared definitions for the parking access machines: FSM encodings and default sizing.
package maquina_de_saida_pkg;

    localparam logic [1:0] OCIOSA           = 2'b00;
    localparam logic [1:0] CANCELA_ABERTA   = 2'b01;
    localparam logic [1:0] VEICULO_PASSANDO = 2'b10;

    localparam int VAGAS_PADRAO        = 16;
    localparam int TEMPO_LIMITE_PADRAO = 1000;

endpackage

// File: rtl/contador_de_vagas.sv
// Saturating occupancy counter; a rejected update produces a one-cycle error pulse.
module contador_de_vagas
    import maquina_de_saida_pkg::*;
#(
    parameter int VAGAS = VAGAS_PADRAO,
    parameter int W     = $clog2(VAGAS + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         incrementa,
    input  logic         decrementa,
    output logic [W-1:0] contagem,
    output logic         cheio,
    output logic         vazio,
    output logic         erro
);

    logic [W-1:0] contagem_r;
    logic [W-1:0] contagem_prox_s;
    logic         erro_r;
    logic         erro_s;

    // Next count: simultaneous entry and exit cancel out, even at the limits.
    always_comb begin
        contagem_prox_s = contagem_r;
        erro_s          = 1'b0;
        case ({incrementa, decrementa})
            2'b10: begin
                if (contagem_r == W'(VAGAS)) begin
                    erro_s = 1'b1;
                end else begin
                    contagem_prox_s = contagem_r + W'(1);
                end
            end
            2'b01: begin
                if (contagem_r == W'(0)) begin
                    erro_s = 1'b1;
                end else begin
                    contagem_prox_s = contagem_r - W'(1);
                end
            end
            default: begin
                contagem_prox_s = contagem_r;
            end
        endcase
    end

    // Count and error registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            contagem_r <= W'(0);
            erro_r     <= 1'b0;
        end else begin
            contagem_r <= contagem_prox_s;
            erro_r     <= erro_s;
        end
    end

    assign contagem = contagem_r;
    assign cheio    = (contagem_r == W'(VAGAS));
    assign vazio    = (contagem_r == W'(0));
    assign erro     = erro_r;

endmodule

// File: rtl/maquina_de_saida.sv
// Exit gate controller: opens on the inner sensor, confirms passage on the outer one,
// closes on completion or timeout, and owns the occupancy counter.
module maquina_de_saida
    import maquina_de_saida_pkg::*;
#(
    parameter int VAGAS        = VAGAS_PADRAO,
    parameter int TEMPO_LIMITE = TEMPO_LIMITE_PADRAO,
    parameter int W            = $clog2(VAGAS + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         SENSOR_INTERNO_SAIDA,
    input  logic         SENSOR_EXTERNO_SAIDA,
    input  logic         ENTRADA_CONFIRMADA,
    output logic         STATUS_DA_CANCELA_DE_SAIDA,
    output logic         cheio,
    output logic         vazio,
    output logic [W-1:0] VAGAS_OCUPADAS,
    output logic         ERRO_DE_CONTAGEM
);

    localparam int TW = $clog2(TEMPO_LIMITE);

    logic [1:0]    estado_r;
    logic [1:0]    estado_prox_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_prox_s;
    logic          cancela_r;
    logic          saida_s;

    // Next state, timer and exit-event decode.
    always_comb begin
        estado_prox_s = estado_r;
        timer_prox_s  = timer_r;
        saida_s       = 1'b0;
        case (estado_r)
            OCIOSA: begin
                if (SENSOR_INTERNO_SAIDA) begin
                    estado_prox_s = CANCELA_ABERTA;
                    timer_prox_s  = TW'(0);
                end else begin
                    estado_prox_s = OCIOSA;
                end
            end
            CANCELA_ABERTA: begin
                // Outer sensor wins over a timeout landing on the same edge.
                if (SENSOR_EXTERNO_SAIDA) begin
                    estado_prox_s = VEICULO_PASSANDO;
                end else if (timer_r == TW'(TEMPO_LIMITE - 1)) begin
                    estado_prox_s = OCIOSA;
                end else begin
                    timer_prox_s = timer_r + TW'(1);
                end
            end
            VEICULO_PASSANDO: begin
                if (!SENSOR_EXTERNO_SAIDA && !SENSOR_INTERNO_SAIDA) begin
                    estado_prox_s = OCIOSA;
                    saida_s       = 1'b1;
                end else if (!SENSOR_EXTERNO_SAIDA) begin
                    estado_prox_s = CANCELA_ABERTA;
                    timer_prox_s  = TW'(0);
                end else begin
                    estado_prox_s = VEICULO_PASSANDO;
                end
            end
            default: begin
                estado_prox_s = OCIOSA;
                timer_prox_s  = TW'(0);
            end
        endcase
    end

    // State, timer and registered gate output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_r  <= OCIOSA;
            timer_r   <= TW'(0);
            cancela_r <= 1'b0;
        end else begin
            estado_r  <= estado_prox_s;
            timer_r   <= timer_prox_s;
            cancela_r <= (estado_prox_s != OCIOSA);
        end
    end

    assign STATUS_DA_CANCELA_DE_SAIDA = cancela_r;

    contador_de_vagas #(
        .VAGAS (VAGAS),
        .W     (W)
    ) u_contador (
        .clk        (clk),
        .rst_n      (rst_n),
        .incrementa (ENTRADA_CONFIRMADA),
        .decrementa (saida_s),
        .contagem   (VAGAS_OCUPADAS),
        .cheio      (cheio),
        .vazio      (vazio),
        .erro       (ERRO_DE_CONTAGEM)
    );

endmodule
